fb_blitter: RTL and testbench

//  Copies the CHIP-8 display area from CPU RAM into video framebuffer RAM, one byte at a time.

---
 rtl/fb_blitter.sv | 235 +++++++++++++++++++++++
 tb/tb_fb_blitter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_blitter.sv
// fb_blitter: copies the CHIP-8 display area from CPU RAM into framebuffer RAM,
// with optional 2x pixel scaling and a zero-fill clear mode.
module fb_blitter #(
   parameter int unsigned CPU_ADDR_W     = 12,
   parameter int unsigned FB_ADDR_W      = 10,
   parameter int unsigned SRC_BASE       = 'h100,
   parameter int unsigned SRC_COLS       = 8,
   parameter int unsigned SRC_ROWS       = 32,
   parameter int unsigned SCALE          = 1,
   parameter int unsigned DST_BASE       = 0,
   parameter int unsigned DST_ROW_STRIDE = 32,
   parameter int unsigned READ_LATENCY   = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start_signal,
   input  logic                  clear_mode,
   output logic                  busy,
   output logic                  finished_signal,
   output logic [CPU_ADDR_W-1:0] cpu_ram_read_address,
   input  logic [7:0]            cpu_ram_out,
   output logic [FB_ADDR_W-1:0]  fb_write_address,
   output logic                  fb_write_enable,
   output logic [7:0]            fb_ram_in
);

   localparam int unsigned ROW_W  = (SRC_ROWS > 1) ? $clog2(SRC_ROWS) : 1;
   localparam int unsigned COL_W  = (SRC_COLS > 1) ? $clog2(SRC_COLS) : 1;
   localparam int unsigned WAIT_W = 2;

   // Reject configurations the datapath cannot express.
   generate
      if (SCALE != 1 && SCALE != 2) begin : g_bad_scale
         $error("fb_blitter: SCALE must be 1 or 2");
      end
      if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_latency
         $error("fb_blitter: READ_LATENCY must be 1..3");
      end
      if (DST_ROW_STRIDE < SRC_COLS * SCALE) begin : g_bad_stride
         $error("fb_blitter: DST_ROW_STRIDE too small for one scaled row");
      end
      if (DST_BASE + (SRC_ROWS * SCALE - 1) * DST_ROW_STRIDE + SRC_COLS * SCALE - 1
          >= (1 << FB_ADDR_W)) begin : g_bad_fit
         $error("fb_blitter: destination rectangle exceeds framebuffer");
      end
   endgenerate

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [ROW_W-1:0]    row_q, row_d;
   logic [COL_W-1:0]    col_q, col_d;
   logic                sr_q, sr_d;
   logic                sc_q, sc_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic                clear_q, clear_d;
   logic [7:0]          byte_q, byte_d;

   logic                  busy_d;
   logic                  finished_d;
   logic [CPU_ADDR_W-1:0] rd_addr_d;
   logic [FB_ADDR_W-1:0]  wr_addr_d;
   logic                  wr_en_d;
   logic [7:0]            wr_data_d;

   logic                  last_sc;
   logic                  last_sub;
   logic                  last_col;
   logic                  last_byte;

   // Framebuffer address of one destination write.
   function automatic logic [FB_ADDR_W-1:0] dst_addr(input logic [ROW_W-1:0] r,
                                                     input logic [COL_W-1:0] c,
                                                     input logic             s_r,
                                                     input logic             s_c);
      int unsigned a;
      a = DST_BASE + (32'(r) * SCALE + 32'(s_r)) * DST_ROW_STRIDE
          + 32'(c) * SCALE + 32'(s_c);
      return FB_ADDR_W'(a);
   endfunction

   // CPU RAM address of one source byte.
   function automatic logic [CPU_ADDR_W-1:0] src_addr(input logic [ROW_W-1:0] r,
                                                      input logic [COL_W-1:0] c);
      int unsigned a;
      a = SRC_BASE + 32'(r) * SRC_COLS + 32'(c);
      return CPU_ADDR_W'(a);
   endfunction

   // Write data for one sub-column: the byte itself, or one half of its pixel-doubled form.
   function automatic logic [7:0] pixel_data(input logic [7:0] b, input logic s_c);
      logic [15:0] e;
      for (int i = 0; i < 8; i++) begin
         e[2*i]   = b[i];
         e[2*i+1] = b[i];
      end
      if (SCALE == 1) begin
         return b;
      end
      return s_c ? e[7:0] : e[15:8];
   endfunction

   assign last_sc   = (sc_q == 1'(SCALE - 1));
   assign last_sub  = (sr_q == 1'(SCALE - 1)) && last_sc;
   assign last_col  = (col_q == COL_W'(SRC_COLS - 1));
   assign last_byte = (row_q == ROW_W'(SRC_ROWS - 1)) && last_col;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state, counters and next output values; outputs follow the state being entered.
   always_comb begin
      state_d   = state_q;
      row_d     = row_q;
      col_d     = col_q;
      sr_d      = sr_q;
      sc_d      = sc_q;
      wait_d    = wait_q;
      clear_d   = clear_q;
      byte_d    = byte_q;
      rd_addr_d = cpu_ram_read_address;
      wr_addr_d = fb_write_address;
      wr_data_d = fb_ram_in;

      unique case (state_q)
         IDLE: begin
            if (start_signal) begin
               clear_d = clear_mode;
               row_d   = '0;
               col_d   = '0;
               sr_d    = 1'b0;
               sc_d    = 1'b0;
               state_d = clear_mode ? WRITE : ISSUE;
            end
         end
         ISSUE: begin
            rd_addr_d = src_addr(row_q, col_q);
            wait_d    = '0;
            state_d   = WAIT;
         end
         WAIT: begin
            if (wait_q == WAIT_W'(READ_LATENCY - 1)) begin
               byte_d  = cpu_ram_out;
               state_d = WRITE;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         WRITE: begin
            if (!last_sub) begin
               if (last_sc) begin
                  sc_d = 1'b0;
                  sr_d = sr_q + 1'b1;
               end else begin
                  sc_d = sc_q + 1'b1;
               end
            end else begin
               sr_d = 1'b0;
               sc_d = 1'b0;
               if (last_byte) begin
                  state_d = DONE;
               end else begin
                  if (last_col) begin
                     col_d = '0;
                     row_d = row_q + 1'b1;
                  end else begin
                     col_d = col_q + 1'b1;
                  end
                  state_d = clear_q ? WRITE : ISSUE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d     = (state_d == ISSUE) || (state_d == WAIT) || (state_d == WRITE);
      finished_d = (state_d == DONE);
      wr_en_d    = (state_d == WRITE);
      if (state_d == WRITE) begin
         wr_addr_d = dst_addr(row_d, col_d, sr_d, sc_d);
         wr_data_d = clear_d ? 8'h00 : pixel_data(byte_d, sc_d);
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         row_q                <= '0;
         col_q                <= '0;
         sr_q                 <= 1'b0;
         sc_q                 <= 1'b0;
         wait_q               <= '0;
         clear_q              <= 1'b0;
         byte_q               <= '0;
         busy                 <= 1'b0;
         finished_signal      <= 1'b0;
         cpu_ram_read_address <= '0;
         fb_write_address     <= '0;
         fb_write_enable      <= 1'b0;
         fb_ram_in            <= '0;
      end else begin
         row_q                <= row_d;
         col_q                <= col_d;
         sr_q                 <= sr_d;
         sc_q                 <= sc_d;
         wait_q               <= wait_d;
         clear_q              <= clear_d;
         byte_q               <= byte_d;
         busy                 <= busy_d;
         finished_signal      <= finished_d;
         cpu_ram_read_address <= rd_addr_d;
         fb_write_address     <= wr_addr_d;
         fb_write_enable      <= wr_en_d;
         fb_ram_in            <= wr_data_d;
      end
   end

endmodule

// File: tb/tb_fb_blitter.sv
// Directed bench for fb_blitter: three instances (defaults, 2x scaling, read latency 3)
// with CPU RAM models whose data is valid only in the expected capture cycle.
module tb_fb_blitter;

   localparam int N = 3;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic        start_v [N];
   logic        clr_v   [N];
   logic        busy_v  [N];
   logic        fin_v   [N];
   logic [11:0] ra_v    [N];
   logic [7:0]  rd_v    [N];
   logic [9:0]  wa_v    [N];
   logic        we_v    [N];
   logic [7:0]  wd_v    [N];

   logic [11:0] a_d1, b_d1, c_d1, c_d2, c_d3;
   int          cyc = 0;

   int          cnt     [N][1024];
   logic [7:0]  mem     [N][1024];
   int          wr_cnt  [N];
   int          busy_cyc[N];
   int          fin_cnt [N];
   int          fin_cyc [N];
   int          last_wr [N];
   int          max_wa  [N];
   int          ra_chg  [N];
   logic [11:0] ra_prev [N];
   logic [9:0]  log_a   [4];
   logic [7:0]  log_d   [4];

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;
   int bad;

   fb_blitter u_a (
      .clk(clk), .reset(reset), .start_signal(start_v[0]), .clear_mode(clr_v[0]),
      .busy(busy_v[0]), .finished_signal(fin_v[0]), .cpu_ram_read_address(ra_v[0]),
      .cpu_ram_out(rd_v[0]), .fb_write_address(wa_v[0]), .fb_write_enable(we_v[0]),
      .fb_ram_in(wd_v[0]));

   fb_blitter #(.SCALE(2), .DST_ROW_STRIDE(16)) u_b (
      .clk(clk), .reset(reset), .start_signal(start_v[1]), .clear_mode(clr_v[1]),
      .busy(busy_v[1]), .finished_signal(fin_v[1]), .cpu_ram_read_address(ra_v[1]),
      .cpu_ram_out(rd_v[1]), .fb_write_address(wa_v[1]), .fb_write_enable(we_v[1]),
      .fb_ram_in(wd_v[1]));

   fb_blitter #(.READ_LATENCY(3)) u_c (
      .clk(clk), .reset(reset), .start_signal(start_v[2]), .clear_mode(clr_v[2]),
      .busy(busy_v[2]), .finished_signal(fin_v[2]), .cpu_ram_read_address(ra_v[2]),
      .cpu_ram_out(rd_v[2]), .fb_write_address(wa_v[2]), .fb_write_enable(we_v[2]),
      .fb_ram_in(wd_v[2]));

   always #5 clk = ~clk;

   // Address history for the RAM models and a cycle counter.
   always @(posedge clk) begin
      cyc  <= cyc + 1;
      a_d1 <= ra_v[0];
      b_d1 <= ra_v[1];
      c_d1 <= ra_v[2];
      c_d2 <= c_d1;
      c_d3 <= c_d2;
   end

   // RAM models: data valid only in the single cycle sampled READ_LATENCY edges after the address edge.
   assign rd_v[0] = (ra_v[0] != a_d1) ? ra_v[0][7:0] : 8'hEE;
   assign rd_v[1] = (ra_v[1] != b_d1) ? ((ra_v[1] == 12'h100) ? 8'hA5 : ra_v[1][7:0]) : 8'hEE;
   assign rd_v[2] = (c_d2 != c_d3) ? (c_d2[7:0] ^ 8'h5A) : 8'hEE;

   // Write/busy/finished monitor.
   always @(negedge clk) begin
      for (int k = 0; k < N; k++) begin
         if (we_v[k] === 1'b1) begin
            if (k == 1 && wr_cnt[1] < 4) begin
               log_a[wr_cnt[1]] = wa_v[1];
               log_d[wr_cnt[1]] = wd_v[1];
            end
            wr_cnt[k]++;
            cnt[k][wa_v[k]]++;
            mem[k][wa_v[k]] = wd_v[k];
            last_wr[k] = cyc;
            if (int'(wa_v[k]) > max_wa[k]) max_wa[k] = int'(wa_v[k]);
         end
         if (busy_v[k] === 1'b1) busy_cyc[k]++;
         if (fin_v[k] === 1'b1) begin
            fin_cnt[k]++;
            fin_cyc[k] = cyc;
         end
         if (ra_v[k] !== ra_prev[k]) ra_chg[k]++;
         ra_prev[k] = ra_v[k];
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clr_stats(input int k);
      for (int a = 0; a < 1024; a++) begin
         cnt[k][a] = 0;
         mem[k][a] = 8'hFF;
      end
      wr_cnt[k]   = 0;
      busy_cyc[k] = 0;
      fin_cnt[k]  = 0;
      fin_cyc[k]  = -1;
      last_wr[k]  = -1;
      max_wa[k]   = -1;
      ra_chg[k]   = 0;
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   // Raise start (and clear_mode) for exactly one rising edge.
   task automatic pulse_start(input int k, input logic clr);
      start_v[k] = 1'b1;
      clr_v[k]   = clr;
      @(posedge clk);
      #1;
      start_v[k] = 1'b0;
      clr_v[k]   = 1'b0;
   endtask

   task automatic wait_fin(input int k, input int budget, input string tag);
      int n;
      n = 0;
      while (fin_v[k] !== 1'b1 && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      check(tag, 64'(fin_v[k]), 64'd1);
   endtask

   task automatic wait_writes(input int k, input int target, input int budget, input string tag);
      int n;
      n = 0;
      while (wr_cnt[k] < target && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      check(tag, 64'(wr_cnt[k]), 64'(target));
   endtask

   // Count destination bytes whose write count or data differ from the expected image.
   // mode 0: copy defaults, 1: clear defaults, 2: 2x scaled, 3: latency-3 copy.
   task automatic verify(input int k, input int mode, output int nbad);
      nbad = 0;
      for (int a = 0; a < 1024; a++) begin
         int          ec;
         int          r;
         int          c;
         logic [7:0]  ed;
         logic [7:0]  src;
         logic [15:0] e;
         ec = 0;
         ed = 8'h00;
         if (mode == 2) begin
            r   = a / 32;
            c   = (a % 16) / 2;
            src = (r == 0 && c == 0) ? 8'hA5 : 8'(r * 8 + c);
            for (int i = 0; i < 8; i++) e[2*i +: 2] = {2{src[i]}};
            ed = (a % 2 == 1) ? e[7:0] : e[15:8];
            ec = 1;
         end else if (a % 32 < 8) begin
            ec = 1;
            ed = (mode == 1) ? 8'h00 : 8'((a / 32) * 8 + a % 32);
            if (mode == 3) ed = ed ^ 8'h5A;
         end
         if (cnt[k][a] != ec || (ec == 1 && mem[k][a] !== ed)) nbad++;
      end
   endtask

   initial begin
      for (int k = 0; k < N; k++) begin
         start_v[k] = 1'b0;
         clr_v[k]   = 1'b0;
         ra_prev[k] = '0;
         clr_stats(k);
      end

      // Reset state
      step(2);
      check("reset_a", 64'({busy_v[0], fin_v[0], ra_v[0], wa_v[0], we_v[0], wd_v[0]}), 64'd0);
      check("reset_b", 64'({busy_v[1], fin_v[1], ra_v[1], wa_v[1], we_v[1], wd_v[1]}), 64'd0);
      check("reset_c", 64'({busy_v[2], fin_v[2], ra_v[2], wa_v[2], we_v[2], wd_v[2]}), 64'd0);
      reset = 1'b0;
      step(2);

      // 1: default copy
      clr_stats(0);
      pulse_start(0, 1'b0);
      wait_fin(0, 2000, "t1_done");
      check("t1_busy_in_done", 64'(busy_v[0]), 64'd0);
      check("t1_writes", 64'(wr_cnt[0]), 64'd256);
      verify(0, 0, bad);
      check("t1_image", 64'(bad), 64'd0);
      check("t1_busy_cycles", 64'(busy_cyc[0]), 64'd768);
      check("t1_fin_after_last_write", 64'(fin_cyc[0] - last_wr[0]), 64'd1);
      step(3);
      check("t1_fin_pulses", 64'(fin_cnt[0]), 64'd1);

      // 2: 2x scaling, stride 16
      clr_stats(1);
      pulse_start(1, 1'b0);
      wait_fin(1, 3000, "t2_done");
      check("t2_w0", 64'({log_a[0], log_d[0]}), 64'({10'd0, 8'hCC}));
      check("t2_w1", 64'({log_a[1], log_d[1]}), 64'({10'd1, 8'h33}));
      check("t2_w2", 64'({log_a[2], log_d[2]}), 64'({10'd16, 8'hCC}));
      check("t2_w3", 64'({log_a[3], log_d[3]}), 64'({10'd17, 8'h33}));
      check("t2_writes", 64'(wr_cnt[1]), 64'd1024);
      check("t2_max_addr", 64'(max_wa[1]), 64'd1023);
      verify(1, 2, bad);
      check("t2_image", 64'(bad), 64'd0);
      check("t2_busy_cycles", 64'(busy_cyc[1]), 64'd1536);

      // 3: clear mode, then start held only during DONE
      step(2);
      clr_stats(0);
      pulse_start(0, 1'b1);
      wait_fin(0, 2000, "t3_done");
      start_v[0] = 1'b1;
      @(posedge clk);
      #1;
      start_v[0] = 1'b0;
      check("t3_writes", 64'(wr_cnt[0]), 64'd256);
      verify(0, 1, bad);
      check("t3_image", 64'(bad), 64'd0);
      check("t3_read_addr_changes", 64'(ra_chg[0]), 64'd0);
      check("t3_busy_cycles", 64'(busy_cyc[0]), 64'd256);
      step(20);
      check("t3_done_start_ignored_busy", 64'(busy_v[0]), 64'd0);
      check("t3_done_start_ignored_writes", 64'(wr_cnt[0]), 64'd256);

      // 4: read latency 3
      clr_stats(2);
      pulse_start(2, 1'b0);
      wait_fin(2, 3000, "t4_done");
      check("t4_writes", 64'(wr_cnt[2]), 64'd256);
      verify(2, 3, bad);
      check("t4_image", 64'(bad), 64'd0);
      check("t4_busy_cycles", 64'(busy_cyc[2]), 64'd1280);

      // 5: reset after 10 writes, then a fresh full transfer
      step(2);
      clr_stats(0);
      pulse_start(0, 1'b0);
      wait_writes(0, 10, 200, "t5_ten_writes");
      reset = 1'b1;
      #1;
      check("t5_reset_outputs",
            64'({busy_v[0], fin_v[0], ra_v[0], wa_v[0], we_v[0], wd_v[0]}), 64'd0);
      step(2);
      reset = 1'b0;
      step(20);
      check("t5_no_more_writes", 64'(wr_cnt[0]), 64'd10);
      check("t5_no_fin", 64'(fin_cnt[0]), 64'd0);
      check("t5_idle", 64'(busy_v[0]), 64'd0);
      clr_stats(0);
      pulse_start(0, 1'b0);
      wait_fin(0, 2000, "t5_rerun_done");
      check("t5_rerun_writes", 64'(wr_cnt[0]), 64'd256);
      verify(0, 0, bad);
      check("t5_rerun_image", 64'(bad), 64'd0);

      // 6: start ignored mid-transfer; start right after DONE accepted
      step(2);
      clr_stats(0);
      pulse_start(0, 1'b0);
      step(100);
      pulse_start(0, 1'b0);
      check("t6_busy_after_mid_start", 64'(busy_v[0]), 64'd1);
      wait_fin(0, 2000, "t6_first_done");
      check("t6_first_writes", 64'(wr_cnt[0]), 64'd256);
      check("t6_first_busy", 64'(busy_cyc[0]), 64'd768);
      @(posedge clk);
      #1;
      pulse_start(0, 1'b0);
      check("t6_restarted", 64'(busy_v[0]), 64'd1);
      wait_fin(0, 2000, "t6_second_done");
      check("t6_total_writes", 64'(wr_cnt[0]), 64'd512);
      check("t6_total_busy", 64'(busy_cyc[0]), 64'd1536);
      check("t6_fin_pulses", 64'(fin_cnt[0]), 64'd2);

      step(2);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
